// File: rtl/heartbeat_sequencer.sv
// Tick-driven lub/gap/dub/rest beat scheduler with decaying brightness level and PWM output.
// Beat parameters are snapshotted on every LUB entry; all outputs are registered.
module heartbeat_sequencer #(
  parameter int TICK_DIV  = 1000,
  parameter int DECAY     = 16,
  parameter int DUB_LEVEL = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] period,
  input  logic [3:0] lub_len,
  input  logic [3:0] gap_len,
  input  logic [3:0] dub_len,
  output logic [7:0] level,
  output logic       pwm_out,
  output logic       beat_strobe,
  output logic [2:0] phase,
  output logic [7:0] beat_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LUB  = 3'd1,
    GAP  = 3'd2,
    DUB  = 3'd3,
    REST = 3'd4
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  state_t        state, state_nx;
  logic [3:0]    ph_cnt, ph_cnt_nx;
  logic [7:0]    beat_tick, beat_tick_nx;
  logic [7:0]    snap_period;
  logic [3:0]    snap_lub, snap_gap, snap_dub, lub_eff;
  logic [7:0]    level_nx;
  logic [7:0]    pwm_cnt;
  logic          enter_lub;

  assign tick    = ena && (presc == PRESC_MAX);
  assign lub_eff = (snap_lub == 4'd0) ? 4'd1 : snap_lub;
  assign phase   = state;

  always_comb begin
    state_nx     = state;
    ph_cnt_nx    = ph_cnt;
    beat_tick_nx = beat_tick;
    level_nx     = level;
    enter_lub    = 1'b0;
    if (tick) begin
      ph_cnt_nx    = ph_cnt + 4'd1;
      beat_tick_nx = beat_tick + 8'd1;
      if (state == IDLE) begin
        ph_cnt_nx    = 4'd0;
        beat_tick_nx = 8'd0;
        enter_lub    = (period != 8'd0);
      end else if (beat_tick == snap_period - 8'd1) begin
        // beat end overrides any phase still in progress
        if (period != 8'd0) enter_lub = 1'b1;
        else                state_nx  = IDLE;
      end else begin
        case (state)
          LUB: if (ph_cnt == lub_eff - 4'd1)
                 state_nx = (snap_gap != 4'd0) ? GAP : ((snap_dub != 4'd0) ? DUB : REST);
          GAP: if (ph_cnt == snap_gap - 4'd1)
                 state_nx = (snap_dub != 4'd0) ? DUB : REST;
          DUB: if (ph_cnt == snap_dub - 4'd1)
                 state_nx = REST;
          default: ;
        endcase
      end
      if (enter_lub) begin
        state_nx     = LUB;
        ph_cnt_nx    = 4'd0;
        beat_tick_nx = 8'd0;
      end else if (state_nx != state) begin
        ph_cnt_nx = 4'd0;
      end
      case (state_nx)
        IDLE:    level_nx = 8'd0;
        LUB:     level_nx = 8'd255;
        DUB:     level_nx = 8'(DUB_LEVEL);
        default: level_nx = (level > 8'(DECAY)) ? level - 8'(DECAY) : 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      state       <= IDLE;
      ph_cnt      <= 4'd0;
      beat_tick   <= 8'd0;
      level       <= 8'd0;
      snap_period <= 8'd0;
      snap_lub    <= 4'd0;
      snap_gap    <= 4'd0;
      snap_dub    <= 4'd0;
      beat_count  <= 8'd0;
      beat_strobe <= 1'b0;
      pwm_cnt     <= 8'd0;
      pwm_out     <= 1'b0;
    end else begin
      if (ena) begin
        presc   <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      state       <= state_nx;
      ph_cnt      <= ph_cnt_nx;
      beat_tick   <= beat_tick_nx;
      level       <= level_nx;
      beat_strobe <= enter_lub;
      if (enter_lub) begin
        snap_period <= period;
        snap_lub    <= lub_len;
        snap_gap    <= gap_len;
        snap_dub    <= dub_len;
        beat_count  <= beat_count + 8'd1;
      end
      pwm_out <= ena && (state != IDLE) && (pwm_cnt < level);
    end
  end

endmodule

// File: doc/heartbeat_sequencer.md
# heartbeat_sequencer

Tick-driven beat scheduler that sequences the heartbeat LED datapath through a lub/gap/dub/rest cycle. It owns the beat timing, generates the brightness level and its PWM output, and flags beat boundaries. It sits between the top-level I/O configuration pins and the LED output pin. All phase lengths are set by runtime configuration and snapshotted at each beat start.

## Interface
- TICK_DIV, 1000: clk cycles per scheduler tick (≥2)
- DECAY, 16: level decrement per tick in GAP/REST, saturating at 0
- DUB_LEVEL, 160: level loaded on DUB entry
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  run enable; low freezes prescaler, FSM, level and counters
- period  in  8  beat length in ticks; 0 = stop after the current beat
- lub_len  in  4  LUB ticks; 0 treated as 1
- gap_len  in  4  GAP ticks; 0 skips GAP
- dub_len  in  4  DUB ticks; 0 skips DUB
- level  out  8  current brightness
- pwm_out  out  1  PWM of level; forced 0 when ena=0 or in IDLE
- beat_strobe  out  1  one-clk pulse on each LUB entry
- phase  out  3  IDLE=0, LUB=1, GAP=2, DUB=3, REST=4
- beat_count  out  8  beats started, wraps 255→0

## Operation
- Prescaler: counts 0..TICK_DIV-1 while ena=1. tick=1 for the single clk where count==TICK_DIV-1. All FSM activity occurs only on tick clks.
- Snapshot: on LUB entry, register period, lub_len, gap_len and dub_len. Input changes mid-beat have no effect until the next beat.
- beat_tick (8b): set to 0 on LUB entry, +1 on each tick within the beat.
- States and transitions, evaluated on tick:
  - IDLE: if period≠0 → LUB; otherwise stay.
  - LUB: after max(lub_len,1) ticks → GAP, or DUB if gap_len=0, or REST if both are 0.
  - GAP: after gap_len ticks → DUB, or REST if dub_len=0.
  - DUB: after dub_len ticks → REST.
  - REST: held until the beat end.
- Beat end has priority over every phase transition. On a tick where beat_tick == snap_period-1, the next state is LUB if the live period≠0, otherwise IDLE. Phases that overrun the period are truncated. If snap_period=1, each tick restarts LUB.
- Level:
  - LUB entry: 255, held during LUB.
  - DUB entry: DUB_LEVEL, held during DUB.
  - GAP/REST: level ← max(level−DECAY, 0) on each tick.
  - IDLE: 0.
- PWM: 8-bit free-running counter pwm_cnt, incremented each clk while ena=1. pwm_out = (pwm_cnt < level) registered. level=255 gives 255/256 duty; level=0 gives constant 0.
- beat_count increments on every LUB entry, wrapping at 255.

## Timing
- Reset (async, immediate):
  - phase=IDLE, level=0, pwm_out=0, beat_strobe=0, beat_count=0
  - prescaler=0, pwm_cnt=0, beat_tick=0, snapshots=0
- State, level, phase, beat_strobe and beat_count update on the clk edge where tick=1. All outputs are registered, with no combinational input→output paths.
- First LUB entry: TICK_DIV clks after ena rises (reset released, period≠0).
- Beat length is exactly snap_period×TICK_DIV clks between beat_strobe pulses.
- ena falling mid-beat: all state is frozen and pwm_out=0. When ena returns, the sequence resumes with the prescaler count preserved.
- Reset mid-beat: returns to IDLE at once. No strobe is produced until the next qualifying tick.

## Test plan
- TICK_DIV=4, period=10, lub=2, gap=1, dub=2: phase sequence is 1,1,2,3,3,4,4,4,4,4 ticks, then 1. beat_strobe is spaced exactly 40 clks apart.
- Level trace for the same config: 255,255 → 239 (GAP) → 160,160 → 144,128,112,96,80. Next LUB reloads 255.
- period=3, lub=2, gap=4, dub=4: the phase trace is LUB,LUB,GAP, then LUB again. GAP is truncated, DUB is never entered, and beat_count increments every 12 clks.
- Set period=0 during the REST of the 2nd beat: the beat completes, then phase=IDLE, level=0, pwm_out=0, with no further strobes. Setting period=5 restarts on the next tick.
- Drop ena for 7 clks mid-DUB: phase, level and beat_tick are unchanged and pwm_out=0. The beat ends 7 clks later than it would have without the pause.
- Assert rst asynchronously mid-LUB (not on a clk edge): all outputs reach reset values immediately. 256 beats make beat_count wrap to 0.
